// File: rtl/seq_attempt_tracker.sv
// seq_attempt_tracker
// Hardware checker for the sequence  a ##1 b ##1 c ##2 d.
// A new attempt may start on every enabled cycle. Overlapping attempts are
// carried as one-hot "alive" flags in a short pipeline (v1..v4). Every cycle
// that sees one or more failures produces a single {stamp, mask} record. The
// record goes into a small FIFO that is drained through a valid/ready port.
// Passes are reported as a registered pulse that carries the attempt's start
// stamp. Pass, fail and drop counts saturate.
//
// FIFO_DEPTH must be a power of two and at least 2. The wrap bit on the
// pointers depends on this to tell full from empty.

module seq_attempt_tracker #(
    parameter int STAMP_W    = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    input  logic               d,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [STAMP_W-1:0] evt_stamp,
    output logic [3:0]         evt_mask,
    output logic               pass_pulse,
    output logic [STAMP_W-1:0] pass_stamp,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // A passing attempt finishes at offset 4, so its start stamp lies 4 cycles back.
    localparam logic [STAMP_W-1:0] PASS_OFFSET = STAMP_W'(4);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    // ------------------------------------------------------------------
    // Free-running stamp and attempt pipeline
    // ------------------------------------------------------------------
    logic [STAMP_W-1:0] stamp;

    // vN = an attempt that started N cycles ago has met every check so far.
    logic v1;
    logic v2;
    logic v3;
    logic v4;

    // Outcome of this cycle's stage checks.
    logic [3:0] fail_mask;
    logic       pass_now;
    logic [2:0] fail_pop;

    // All stage checks run in parallel on the current inputs.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first.
        // Otherwise a path that skips an assignment infers a latch.
        fail_mask = 4'b0000;
        pass_now  = 1'b0;

        fail_mask[0] = en & ~a;
        fail_mask[1] = v1 & ~b;
        fail_mask[2] = v2 & ~c;
        fail_mask[3] = v4 & ~d;
        pass_now     = v4 & d;

        fail_pop = 3'(fail_mask[0]) + 3'(fail_mask[1])
                 + 3'(fail_mask[2]) + 3'(fail_mask[3]);
    end

    // Advance the stamp and move surviving attempts one stage along.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. That way every
        // stage samples the values from before the edge, not values already
        // updated in this block.
        if (rst) begin
            stamp <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            v4    <= 1'b0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
            v1    <= en & a;
            v2    <= v1 & b;
            v3    <= v2 & c;
            v4    <= v3;          // offset 3 has no term to check
        end
    end

    // An attempt is in flight whenever any stage holds a live one.
    assign busy = v1 | v2 | v3 | v4;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [STAMP_W-1:0] stamp_mem [FIFO_DEPTH];
    logic [3:0]         mask_mem  [FIFO_DEPTH];

    // The extra top bit separates full from empty when the indices are equal.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic drop;

    // Work out FIFO occupancy and what this cycle's push and pop will do.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = ~fifo_empty & evt_ready;
        push_req   = |fail_mask;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok    = push_req & (~fifo_full | pop);
        drop       = push_req & fifo_full & ~pop;
    end

    // Write one record into the storage array.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is never reset. The pointers decide which
        // entries are valid, so clearing the data would gain nothing.
        if (push_ok) begin
            stamp_mem[wr_ptr[AW-1:0]] <= stamp;
            mask_mem[wr_ptr[AW-1:0]]  <= fail_mask;
        end
    end

    // Move the pointers. A reset empties the FIFO at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // The head record is read straight from storage. Its slot is not written
    // while it waits, so the outputs stay stable under back-pressure.
    assign evt_valid = ~fifo_empty;
    assign evt_stamp = stamp_mem[rd_ptr[AW-1:0]];
    assign evt_mask  = mask_mem[rd_ptr[AW-1:0]];

    // ------------------------------------------------------------------
    // Pass reporting
    // ------------------------------------------------------------------
    // Report a pass one cycle late. pass_stamp keeps its last value between passes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_pulse <= 1'b0;
            pass_stamp <= '0;
        end else begin
            pass_pulse <= pass_now;
            if (pass_now) begin
                pass_stamp <= stamp - PASS_OFFSET;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    logic [CNT_W:0]   fail_sum;
    logic [CNT_W-1:0] fail_next;

    // Up to four failures can land in one cycle. One carry bit is enough to
    // detect overflow before clamping.
    always_comb begin
        fail_sum  = {1'b0, fail_cnt} + (CNT_W+1)'(fail_pop);
        fail_next = fail_sum[CNT_W] ? CNT_MAX : fail_sum[CNT_W-1:0];
    end

    // Update the pass, fail and drop counters. Each one clamps at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (pass_now && (pass_cnt != CNT_MAX)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            fail_cnt <= fail_next;
            if (drop && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_attempt_tracker.sv
// tb_seq_attempt_tracker
// Directed scenarios followed by randomized traffic. Every cycle the DUT is
// compared against a reference model. The model keeps the input history
// indexed by cycle and applies the sequence rules to it: an attempt started
// at s fails term k at s+off[k] if every earlier term held. Small stamp and
// counter widths let the bench reach stamp wrap and counter saturation.

module tb_seq_attempt_tracker;

    localparam int SW    = 4;
    localparam int CW    = 5;
    localparam int DEPTH = 8;
    localparam int HIST  = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [SW-1:0] evt_stamp;
    logic [3:0]    evt_mask;
    logic          pass_pulse;
    logic [SW-1:0] pass_stamp;
    logic [CW-1:0] pass_cnt, fail_cnt, drop_cnt;
    logic          busy;

    seq_attempt_tracker #(.STAMP_W(SW), .CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_stamp(evt_stamp), .evt_mask(evt_mask),
        .pass_pulse(pass_pulse), .pass_stamp(pass_stamp),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [SW-1:0] st;
        logic [3:0]    mk;
    } rec_t;

    bit   en_h [HIST];
    bit   a_h  [HIST];
    bit   b_h  [HIST];
    bit   c_h  [HIST];
    bit   d_h  [HIST];
    int   cyc;
    rec_t q[$];
    int   m_pass, m_fail, m_drop, m_pstamp;
    bit   m_pulse;
    int   cnt_max = (1 << CW) - 1;

    function automatic int off(int k);
        case (k)
            0:       return 0;
            1:       return 1;
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit term(int k, int cy);
        case (k)
            0:       return a_h[cy];
            1:       return b_h[cy];
            2:       return c_h[cy];
            default: return d_h[cy];
        endcase
    endfunction

    // True if attempt s was started and terms 0..n-1 all held.
    function automatic bit held_upto(int s, int n);
        if (!en_h[s]) return 1'b0;
        for (int k = 0; k < n; k++)
            if (!term(k, s + off(k))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_busy(int t);
        for (int s = t - 4; s < t; s++) begin
            int nchk;
            if (s < 0) continue;
            nchk = (t - s >= 4) ? 3 : (t - s);
            if (held_upto(s, nchk)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int sat(int v);
        return (v > cnt_max) ? cnt_max : v;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        q.delete();
        m_pass   = 0;
        m_fail   = 0;
        m_drop   = 0;
        m_pstamp = 0;
        m_pulse  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_all();
        check("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("evt_stamp", 32'(evt_stamp), 32'(q[0].st));
            check("evt_mask",  32'(evt_mask),  32'(q[0].mk));
        end
        check("busy",       32'(busy),       32'(model_busy(cyc)));
        check("pass_pulse", 32'(pass_pulse), 32'(m_pulse));
        check("pass_stamp", 32'(pass_stamp), 32'(m_pstamp));
        check("pass_cnt",   32'(pass_cnt),   32'(m_pass));
        check("fail_cnt",   32'(fail_cnt),   32'(m_fail));
        check("drop_cnt",   32'(drop_cnt),   32'(m_drop));
    endtask

    // One clock cycle, entered and left at a negedge: check, drive, model, advance.
    task automatic step(input bit ie, ia, ib, ic, id, ir);
        logic [3:0] mask;
        bit         pass;
        bit         pop;
        check_all();
        en = ie; a = ia; b = ib; c = ic; d = id; evt_ready = ir;
        en_h[cyc] = ie; a_h[cyc] = ia; b_h[cyc] = ib; c_h[cyc] = ic; d_h[cyc] = id;
        mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int s = cyc - off(k);
            if (s >= 0 && held_upto(s, k) && !term(k, cyc)) mask[k] = 1'b1;
        end
        pass = (cyc >= 4) && held_upto(cyc - 4, 4);
        pop  = (q.size() != 0) && ir;
        if (pop) void'(q.pop_front());
        if (mask != 4'b0000) begin
            if (q.size() < DEPTH) q.push_back('{st: SW'(cyc), mk: mask});
            else                  m_drop = sat(m_drop + 1);
        end
        m_fail  = sat(m_fail + $countones(mask));
        if (pass) begin
            m_pass   = sat(m_pass + 1);
            m_pstamp = (cyc - 4) & ((1 << SW) - 1);
        end
        m_pulse = pass;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0; d = 1'b0; evt_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single pass
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("t1_pulse", 32'(pass_pulse), 32'd1);
        check("t1_pstamp", 32'(pass_stamp), 32'd0);
        check("t1_pcnt", 32'(pass_cnt), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_valid", 32'(evt_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("t1_pulse_off", 32'(pass_pulse), 32'd0);

        // 2: continuous a-fail, consumer always ready
        do_reset();
        check("t2_rst_pcnt", 32'(pass_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 1);
            check("t2_rec_stamp", 32'(evt_stamp), 32'(i));
        end
        check("t2_fcnt", 32'(fail_cnt), 32'd3);

        // 3: two failures in the same cycle form a single record
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t3_valid", 32'(evt_valid), 32'd1);
        check("t3_stamp", 32'(evt_stamp), 32'd2);
        check("t3_mask", 32'(evt_mask), 32'h6);
        check("t3_fcnt", 32'(fail_cnt), 32'd2);
        check("t3_pcnt", 32'(pass_cnt), 32'd0);
        step(0, 0, 0, 0, 0, 1);

        // 4: overflow, then drain in order
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
        check("t4_drop", 32'(drop_cnt), 32'd2);
        check("t4_valid", 32'(evt_valid), 32'd1);
        check("t4_head", 32'(evt_stamp), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        check("t4_hold", 32'(evt_stamp), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_stamp", 32'(evt_stamp), 32'(i));
            check("t4_drain_mask", 32'(evt_mask), 32'h1);
            step(0, 0, 0, 0, 0, 1);
        end
        check("t4_empty", 32'(evt_valid), 32'd0);

        // 4b: full FIFO with a simultaneous pop accepts the push
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        check("t4b_nodrop", 32'(drop_cnt), 32'd0);
        check("t4b_head", 32'(evt_stamp), 32'd1);

        // 5: reset while an attempt is in flight
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        do_reset();
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_fcnt", 32'(fail_cnt), 32'd0);
        check("t5_valid", 32'(evt_valid), 32'd0);
        step(1, 0, 1, 1, 1, 0);
        check("t5_restart_stamp", 32'(evt_stamp), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 1, 0);
        check("t5_pcnt", 32'(pass_cnt), 32'd0);
        check("t5_fcnt_after", 32'(fail_cnt), 32'd1);

        // 6: stamp wrap on a 4-bit stamp
        do_reset();
        for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("t6_pulse", 32'(pass_pulse), 32'd1);
        check("t6_pstamp", 32'(pass_stamp), 32'd14);

        // 7: randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit rdy_hi = ((i / 100) % 2) == 0;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                     $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                     $urandom_range(0, 4) != 0,
                     rdy_hi ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            end
        end
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_attempt_tracker.md
Name: seq_attempt_tracker

Overview:
- Synthesizable RTL checker for the sequence a ##1 b ##1 c ##2 d, evaluated at posedge clk with one new attempt per enabled cycle.
- Overlapping attempts are tracked in a pipeline.
- Each cycle with one or more failures is compressed into a timestamped event record, buffered in a FIFO and drained through a valid/ready port.
- The block sits directly downstream of the DUT signal bundle and feeds the bench scoreboard and log collector, mirroring the concurrent assertion's pass/fail reporting in hardware.

Parameters:
- STAMP_W, 16, width of the free-running cycle stamp; wraps modulo 2^STAMP_W.
- CNT_W, 16, width of the pass, fail and drop counters; all saturate.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start a new attempt this cycle.
- a  in  1  sequence term, offset 0.
- b  in  1  sequence term, offset 1.
- c  in  1  sequence term, offset 2.
- d  in  1  sequence term, offset 4.
- evt_valid  out  1  event record available at FIFO head.
- evt_ready  in  1  consumer accepts the head record.
- evt_stamp  out  STAMP_W  cycle stamp at which the failures were detected.
- evt_mask  out  4  failure mask: bit0 = a low at offset 0, bit1 = b low at offset 1, bit2 = c low at offset 2, bit3 = d low at offset 4.
- pass_pulse  out  1  one-cycle pulse: an attempt completed successfully.
- pass_stamp  out  STAMP_W  start stamp of the passing attempt.
- pass_cnt  out  CNT_W  number of passed attempts.
- fail_cnt  out  CNT_W  number of failed attempts.
- drop_cnt  out  CNT_W  number of event records lost to FIFO full.
- busy  out  1  at least one attempt is in flight (v1..v4 nonzero).

Behaviour:
- Reset: while rst=1 at a posedge, the following are cleared to 0: stamp, v1..v4, FIFO pointers, all counters, pass_pulse, pass_stamp, evt_valid, busy. This applies mid-operation: in-flight attempts vanish silently and a FIFO holding data is flushed.
- Stamp: 0 on the first cycle after reset, then +1 every cycle, wrapping.
- Per cycle t, all stages are evaluated in parallel on the values sampled at the edge:
  - Stage 0: if en, a=1 sets v1; a=0 sets mask bit0.
  - Stage 1: if v1, b=1 sets v2; b=0 sets mask bit1.
  - Stage 2: if v2, c=1 sets v3; c=0 sets mask bit2.
  - Stage 3: v4 <= v3 unconditionally (no check).
  - Stage 4: if v4, d=1 is a pass; d=0 sets mask bit3.
- Implied start stamp of a failure in bit k: stamp_t minus offset {0,1,2,4}[k], modulo 2^STAMP_W.
- Driving en low only suppresses new attempts; attempts already in flight continue.
- Event push: if mask is nonzero in cycle t, {stamp_t, mask} is written at the end of cycle t. One entry holds up to 4 simultaneous failures.
  - Earliest evt_valid is at t+1, when the FIFO was empty.
  - FIFO is first-in first-out, with no bypass.
- Handshake: a pop occurs when evt_valid & evt_ready. evt_stamp/evt_mask hold stable while evt_valid=1 and evt_ready=0.
- FIFO full boundary:
  - Push with full and no pop: the record is dropped and drop_cnt +1.
  - Push with full and a simultaneous pop: accepted, no drop.
  - Pop with empty: ignored.
- Pass reporting: registered. pass_pulse=1 in cycle t+1 with pass_stamp = stamp_t - 4 (wrapped). Otherwise pass_pulse=0 and pass_stamp holds its last value.
- Counters update at the end of cycle t and are visible at t+1:
  - pass_cnt += 1 per pass.
  - fail_cnt += popcount(mask).
  - All counters saturate at 2^CNT_W-1.
- busy is combinational from v1..v4.

Test Plan:
1. Single pass: en=1 only at stamp 0; a=1@0, b=1@1, c=1@2, d=1@4. Response: pass_pulse at stamp 5 with pass_stamp=0, pass_cnt=1, evt_valid never asserted, busy=0 from stamp 5.
2. Continuous a-fail: en=1 and a=b=c=d=0 for stamps 0..2, evt_ready=1. Response: records {0,0001}, {1,0001}, {2,0001} appear at stamps 1, 2, 3; fail_cnt=3.
3. Multi-fail same cycle: en=1 at stamps 0 and 1; a=1@0, a=1@1, b=1@1, b=0@2, c=0@2. Response: single record {2,0110}; fail_cnt=2; pass_cnt=0.
4. Overflow: FIFO_DEPTH=8, evt_ready=0, en=1, a=0 for stamps 0..9. Response:
   - FIFO holds 8 records, drop_cnt=2, evt_valid=1 stable.
   - After evt_ready=1, stamps 0..7 drain in order, each with mask 0001.
   - Then evt_valid=0.
5. Reset mid-flight: attempt from stamp 0 with a=1, b=1; rst=1 at stamp 2. Response:
   - After reset: busy=0, counters=0, evt_valid=0, stamp restarts at 0.
   - No pass or fail is ever reported for that attempt.
6. Stamp wrap: STAMP_W=4; passing attempt started at stamp 14. Response: pass_pulse when stamp=3, pass_stamp=14.
